fifo_wr_arbiter_4x40: RTL and testbench
=======================================

FIFO_WR_ARBITER_4X40 -- requirements
Module: fifo_wr_arbiter_4x40

Interface
REQ-001 SHALL have parameter DW, default 40, data word width.
REQ-002 SHALL have parameter AW, default 8, FIFO address width; DEPTH = 1<<AW (256).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clr  input  1  synchronous clear of all state.
REQ-006 SHALL have port req  input  4  per-requester write request, one bit per requester.
REQ-007 SHALL have port req_data  input  4*DW  requester i data on bits [i*DW +: DW].
REQ-008 SHALL have port req_last  input  4  end-of-burst marker, used only with FIFO_ARB_LOCK_EN.
REQ-009 SHALL have port gnt  output  4  one-hot combinational accept; req[i]&gnt[i] = word transferred this cycle.
REQ-010 SHALL have port fifo_we  output  1  registered write strobe to the downstream FIFO.
REQ-011 SHALL have port fifo_din  output  DW  registered write data to the downstream FIFO.
REQ-012 SHALL have port fifo_clr  output  1  registered clear to the downstream FIFO.
REQ-013 SHALL have port fifo_re  input  1  read strobe issued to the downstream FIFO, observed for credit.
REQ-014 SHALL have port level  output  AW+1  words accepted and not yet read, 0..DEPTH.

Function
REQ-015 SHALL assert at most one gnt bit per cycle, only where req is high, only when level < DEPTH and clr is low.
REQ-016 SHALL arbitrate round-robin: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requesting index wins.
REQ-017 SHALL set ptr to (winner+1) mod 4 on each accepted word; ptr unchanged when nothing accepted.
REQ-018 SHALL drive fifo_we=1 and fifo_din=winner's req_data on the cycle after acceptance (latency 1); fifo_we=0 otherwise.
REQ-019 SHALL update level next cycle: +1 on accept only, -1 on fifo_re only (when level != 0), unchanged on both or neither.
REQ-020 SHALL ignore fifo_re while level == 0 (no underflow); level never exceeds DEPTH.
REQ-021 SHALL not accept at level == DEPTH even if fifo_re is high that cycle; acceptance resumes the next cycle.
REQ-022 SHALL on clr: gnt=0 that cycle; next cycle level=0, ptr=0, lock state IDLE, fifo_we=0, fifo_clr=1 for exactly one cycle.
REQ-023 SHALL register fifo_clr as clr delayed one cycle, aligned with the fifo_we pipeline.

Reset
REQ-024 SHALL on rst asynchronously force fifo_we=0, fifo_din=0, fifo_clr=0, level=0, ptr=0, lock state IDLE.
REQ-025 SHALL hold gnt=0 while rst is high; words in flight at reset are discarded.

Configuration
REQ-026 SHALL implement burst lock only when macro FIFO_ARB_LOCK_EN is defined.
REQ-027 SHALL with FIFO_ARB_LOCK_EN use states IDLE/LOCKED: IDLE->LOCKED on accepting a word with req_last[winner]=0, recording owner.
REQ-028 SHALL in LOCKED grant only the owner; LOCKED->IDLE on accepting owner's word with req_last=1; ptr advances only on that exit.
REQ-029 SHALL in LOCKED stall (gnt=0) while level == DEPTH without leaving LOCKED.
REQ-030 SHALL without FIFO_ARB_LOCK_EN ignore req_last and rotate per word (REQ-016/017).

Verification
REQ-031 SHALL cover: after reset, req=4'b1111 held 4 cycles -> gnt 0001,0010,0100,1000; fifo_we high cycles 2-5 with data of req 0,1,2,3.
REQ-032 SHALL cover: req=4'b0001 continuous, fifo_re=0 -> 256 accepts, level=256, gnt=0 on cycle 257; one fifo_re pulse -> level 255, one more accept.
REQ-033 SHALL cover: level=10, accept and fifo_re same cycle -> level stays 10; fifo_re at level=0 -> level stays 0.
REQ-034 SHALL cover: clr asserted with req=4'b0110 -> gnt=0 that cycle, next cycle level=0, fifo_clr=1 one cycle, next grant to requester 1.
REQ-035 SHALL cover (FIFO_ARB_LOCK_EN): req=4'b0011, req0 burst of 3 words, last on word 3 -> gnt=0001 three cycles, then 0010.
REQ-036 SHALL cover: rst asserted mid-stream -> fifo_we, level, gnt zero immediately, without waiting for clk.

Source files
------------

// File: rtl/fifo_wr_arbiter_4x40.sv
// Four-requester round-robin write arbiter feeding a downstream FIFO, with credit-based level tracking.
// Optional burst lock is enabled by defining FIFO_ARB_LOCK_EN.
module fifo_wr_arbiter_4x40 #(
  parameter int DW = 40,
  parameter int AW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] req_data,
  input  logic [3:0]      req_last,
  output logic [3:0]      gnt,
  output logic            fifo_we,
  output logic [DW-1:0]   fifo_din,
  output logic            fifo_clr,
  input  logic            fifo_re,
  output logic [AW:0]     level
);

  localparam logic [AW:0] FULL_LVL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE_LVL  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] ZERO_LVL = {(AW+1){1'b0}};

  // Returns {found, index}; scanning downward lets the lowest offset from p win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [1:0]    ptr_r;
  logic [AW:0]   level_r;
  logic          fifo_we_r;
  logic [DW-1:0] fifo_din_r;
  logic          fifo_clr_r;

  logic [2:0]    pick_s;
  logic [1:0]    win_s;
  logic [3:0]    gnt_s;
  logic          accept_s;
  logic          full_s;
  logic          re_eff_s;
  logic          ptr_adv_s;
  logic [DW-1:0] win_data_s;

`ifdef FIFO_ARB_LOCK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  logic [0:0] state_r;
  logic [1:0] owner_r;
`else
  logic unused_last_s;
  assign unused_last_s = ^req_last;
`endif

  assign pick_s   = rr_pick(req, ptr_r);
  assign full_s   = (level_r == FULL_LVL);
  assign re_eff_s = fifo_re && (level_r != ZERO_LVL);
  assign accept_s = |gnt_s;

  // Winner selection and one-hot grant; reset, clear and full all block acceptance.
  always_comb begin
    win_s = pick_s[1:0];
    gnt_s = 4'b0000;
`ifdef FIFO_ARB_LOCK_EN
    if (state_r == ST_LOCKED) begin
      win_s = owner_r;
    end else begin
      win_s = pick_s[1:0];
    end
`endif
    if (rst || clr || full_s) begin
      gnt_s = 4'b0000;
    end
`ifdef FIFO_ARB_LOCK_EN
    else if (state_r == ST_LOCKED) begin
      gnt_s = req[owner_r] ? (4'b0001 << owner_r) : 4'b0000;
    end
`endif
    else if (pick_s[2]) begin
      gnt_s = 4'b0001 << pick_s[1:0];
    end else begin
      gnt_s = 4'b0000;
    end
  end

  // Data mux for the winning requester.
  always_comb begin
    case (win_s)
      2'd0:    win_data_s = req_data[0*DW +: DW];
      2'd1:    win_data_s = req_data[1*DW +: DW];
      2'd2:    win_data_s = req_data[2*DW +: DW];
      2'd3:    win_data_s = req_data[3*DW +: DW];
      default: win_data_s = {DW{1'b0}};
    endcase
  end

`ifdef FIFO_ARB_LOCK_EN
  // Inside a burst the pointer stays put; it moves only when the burst's last word goes.
  assign ptr_adv_s = req_last[win_s];

  // Burst lock state: enter on a non-last word, leave on the owner's last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      owner_r <= 2'd0;
    end else if (clr) begin
      state_r <= ST_IDLE;
      owner_r <= 2'd0;
    end else if (accept_s) begin
      state_r <= req_last[win_s] ? ST_IDLE : ST_LOCKED;
      owner_r <= win_s;
    end else begin
      state_r <= state_r;
      owner_r <= owner_r;
    end
  end
`else
  assign ptr_adv_s = 1'b1;
`endif

  // Write pipeline, clear pipeline, credit level and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r      <= 2'd0;
      level_r    <= ZERO_LVL;
      fifo_we_r  <= 1'b0;
      fifo_din_r <= {DW{1'b0}};
      fifo_clr_r <= 1'b0;
    end else if (clr) begin
      ptr_r      <= 2'd0;
      level_r    <= ZERO_LVL;
      fifo_we_r  <= 1'b0;
      fifo_din_r <= {DW{1'b0}};
      fifo_clr_r <= 1'b1;
    end else begin
      fifo_we_r  <= accept_s;
      fifo_clr_r <= 1'b0;
      if (accept_s) begin
        fifo_din_r <= win_data_s;
      end
      if (accept_s && ptr_adv_s) begin
        ptr_r <= win_s + 2'd1;
      end
      case ({accept_s, re_eff_s})
        2'b10:   level_r <= level_r + ONE_LVL;
        2'b01:   level_r <= level_r - ONE_LVL;
        default: level_r <= level_r;
      endcase
    end
  end

  assign gnt      = gnt_s;
  assign fifo_we  = fifo_we_r;
  assign fifo_din = fifo_din_r;
  assign fifo_clr = fifo_clr_r;
  assign level    = level_r;

endmodule

// File: tb/tb_fifo_wr_arbiter_4x40.sv
// Directed bench for fifo_wr_arbiter_4x40: grants and levels are checked inline,
// written words flow through a due-cycle scoreboard checked by a separate monitor.
module tb_fifo_wr_arbiter_4x40;

  localparam int DW = 40;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_last;
  logic [3:0]      gnt;
  logic            fifo_we;
  logic [DW-1:0]   fifo_din;
  logic            fifo_clr;
  logic            fifo_re;
  logic [AW:0]     level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  int            due_q[$];

  fifo_wr_arbiter_4x40 #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .req(req), .req_data(req_data),
    .req_last(req_last), .gnt(gnt), .fifo_we(fifo_we), .fifo_din(fifo_din),
    .fifo_clr(fifo_clr), .fifo_re(fifo_re), .level(level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs already applied: check grant, queue the expected word, advance.
  task automatic step(input string nm, input logic [3:0] eg);
    logic [DW-1:0] d;
    #1;
    chk(nm, 64'(gnt), 64'(eg));
    if (eg != 4'b0000) begin
      d = '0;
      for (int i = 0; i < 4; i++) if (eg[i]) d = req_data[i*DW +: DW];
      exp_q.push_back(d);
      due_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every fifo_we must match the oldest expected word on exactly its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL fifo_we_missing actual=0 required=1 word=%0h", exp_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
      if (fifo_we) begin
        if (due_q.size() == 0 || due_q[0] != cyc) begin
          checks++;
          errors++;
          $display("FAIL fifo_we_unexpected actual=1 required=0 din=%0h", fifo_din);
        end else begin
          void'(due_q.pop_front());
          chk("fifo_din", 64'(fifo_din), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; req = 4'b1111; req_last = 4'b0000; fifo_re = 1'b0;
    req_data = {40'hA3_0000_0003, 40'hA2_0000_0002, 40'hA1_0000_0001, 40'hA0_0000_0000};
    #2;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_we", 64'(fifo_we), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_fifo_clr", 64'(fifo_clr), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin over all four requesters.
    step("rr_gnt0", 4'b0001);
    step("rr_gnt1", 4'b0010);
    step("rr_gnt2", 4'b0100);
    step("rr_gnt3", 4'b1000);
    req = 4'b0000;
    step("rr_idle", 4'b0000);
    chk("rr_level4", 64'(level), 64'd4);
    fifo_re = 1'b1;
    for (int i = 0; i < 4; i++) step("drain_gnt", 4'b0000);
    chk("drain_level0", 64'(level), 64'd0);
    step("re_at_empty", 4'b0000);
    chk("no_underflow", 64'(level), 64'd0);
    fifo_re = 1'b0;

    // Simultaneous accept and read at level 10.
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      req_data[DW-1:0] = 40'h33_0000_0000 | 40'(i);
      step("fill10_gnt", 4'b0001);
    end
    chk("level10", 64'(level), 64'd10);
    fifo_re = 1'b1;
    req_data[DW-1:0] = 40'h33_0000_00FF;
    step("both_gnt", 4'b0001);
    chk("both_level10", 64'(level), 64'd10);
    req = 4'b0000;
    for (int i = 0; i < 10; i++) step("drain10_gnt", 4'b0000);
    chk("drain10_level0", 64'(level), 64'd0);
    fifo_re = 1'b0;

    // Fill to DEPTH, then one read credit allows exactly one more word.
    req = 4'b0001;
    for (int i = 0; i < 256; i++) begin
      req_data[DW-1:0] = 40'h55_0000_0000 | 40'(i);
      step("flood_gnt", 4'b0001);
    end
    chk("full_level256", 64'(level), 64'd256);
    step("full_block", 4'b0000);
    fifo_re = 1'b1;
    step("full_re_block", 4'b0000);
    fifo_re = 1'b0;
    chk("after_re_level255", 64'(level), 64'd255);
    req_data[DW-1:0] = 40'h66_0000_0001;
    step("resume_gnt", 4'b0001);
    chk("refull_level256", 64'(level), 64'd256);
    step("refull_block", 4'b0000);

    // Synchronous clear while full.
    clr = 1'b1; req = 4'b0110;
    step("clr_gnt", 4'b0000);
    clr = 1'b0;
    chk("clr_level0", 64'(level), 64'd0);
    chk("clr_pulse_hi", 64'(fifo_clr), 64'd1);
    step("post_clr_gnt1", 4'b0010);
    chk("clr_pulse_lo", 64'(fifo_clr), 64'd0);
    step("post_clr_gnt2", 4'b0100);
    req = 4'b0000;
    step("post_clr_idle", 4'b0000);
    chk("post_clr_level2", 64'(level), 64'd2);

    // Burst of three from requester 0 against requester 1 (pointer currently 3).
    req = 4'b0011;
`ifdef FIFO_ARB_LOCK_EN
    step("burst_w1", 4'b0001);
    step("burst_w2", 4'b0001);
    req_last = 4'b0001;
    step("burst_w3", 4'b0001);
    req_last = 4'b0000;
    step("burst_next", 4'b0010);
`else
    step("burst_w1", 4'b0001);
    step("burst_w2", 4'b0010);
    req_last = 4'b0001;
    step("burst_w3", 4'b0001);
    req_last = 4'b0000;
    step("burst_next", 4'b0010);
`endif
    req = 4'b0000;
    step("burst_idle", 4'b0000);
    chk("burst_level6", 64'(level), 64'd6);

    // Asynchronous reset mid-stream.
    req = 4'b0010;
    step("pre_rst_gnt_a", 4'b0010);
    step("pre_rst_gnt_b", 4'b0010);
    #1;
    chk("we_before_rst", 64'(fifo_we), 64'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    due_q.delete();
    #1;
    chk("async_rst_we", 64'(fifo_we), 64'd0);
    chk("async_rst_level", 64'(level), 64'd0);
    chk("async_rst_gnt", 64'(gnt), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step("post_rst_gnt", 4'b0010);
    req = 4'b0000;
    step("end_idle_a", 4'b0000);
    step("end_idle_b", 4'b0000);
    chk("end_level1", 64'(level), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
